// File: rtl/unified_mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package unified_mem_arb_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    // Grant decision: round-robin on contention when fair, else data first.
    function automatic port_e pick_port(input logic inst_req, input logic data_req,
                                        input port_e last_gnt, input logic fair);
        if (inst_req && data_req) begin
            return (fair && last_gnt == PORT_DATA) ? PORT_INST : PORT_DATA;
        end
        return data_req ? PORT_DATA : PORT_INST;
    endfunction

endpackage

// File: rtl/unified_mem_arb_if.sv
// Fetch and load/store handshake bundle between the CPU core and the memory.
interface unified_mem_arb_if
    import unified_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              inst_ce;
    logic [31:0]       inst_addr;
    logic [DATA_W-1:0] inst_o;
    logic              inst_ready;

    logic              data_ce;
    logic              data_we;
    logic [SEL_W-1:0]  data_sel;
    logic [31:0]       data_addr;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              data_ready;

    modport master (
        output inst_ce, inst_addr,
        input  inst_o, inst_ready,
        output data_ce, data_we, data_sel, data_addr, data_i,
        input  data_o, data_ready
    );

    modport slave (
        input  inst_ce, inst_addr,
        output inst_o, inst_ready,
        input  data_ce, data_we, data_sel, data_addr, data_i,
        output data_o, data_ready
    );

endinterface

// File: rtl/unified_mem_arb_ram.sv
// Single-port synchronous array with per-byte write enables and registered read.
module unified_mem_arb_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned SEL_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [SEL_W-1:0]  sel,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Commit a byte-masked write, or capture the addressed word on a read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < SEL_W; i++) begin
                    if (sel[i]) begin
                        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/unified_mem_arb.sv
// Two-master arbiter in front of a shared byte-writable instruction/data array.
module unified_mem_arb
    import unified_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned FAIR        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    unified_mem_arb_if.slave bus
);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned AW    = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    port_e             gnt_q, gnt_d;
    port_e             last_q, last_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] inst_o_q, inst_o_d;
    logic [DATA_W-1:0] data_o_q, data_o_d;
    logic              inst_ready_q, inst_ready_d;
    logic              data_ready_q, data_ready_d;

    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;
    port_e             pick;

    // Byte offset and bits above the word index are don't-care (addresses alias).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.inst_addr[31:AW+2], bus.inst_addr[1:0],
                                bus.data_addr[31:AW+2], bus.data_addr[1:0]};

    assign pick = pick_port(bus.inst_ce, bus.data_ce, last_q, FAIR != 0);

    // Next-state, latched-request and output-register computation.
    // The array read lands in the RAM register on the commit edge, so the port
    // register and ready are loaded on the RESP edge and appear one cycle later.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        we_d         = we_q;
        sel_d        = sel_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        inst_o_d     = inst_o_q;
        data_o_d     = data_o_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        ram_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.inst_ce || bus.data_ce) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ST_ACCESS;
                    if (pick == PORT_DATA) begin
                        we_d    = bus.data_we;
                        sel_d   = bus.data_sel;
                        idx_d   = bus.data_addr[AW+1:2];
                        wdata_d = bus.data_i;
                    end else begin
                        we_d    = 1'b0;
                        sel_d   = '0;
                        idx_d   = bus.inst_addr[AW+1:2];
                        wdata_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ram_en  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (gnt_q == PORT_DATA) begin
                    data_ready_d = 1'b1;
                    if (!we_q) begin
                        data_o_d = ram_rdata;
                    end
                end else begin
                    inst_ready_d = 1'b1;
                    inst_o_d     = ram_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, latched transfer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gnt_q        <= PORT_INST;
            last_q       <= PORT_INST;
            we_q         <= 1'b0;
            sel_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            inst_o_q     <= '0;
            data_o_q     <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            inst_o_q     <= inst_o_d;
            data_o_q     <= data_o_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
        end
    end

    unified_mem_arb_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .sel   (sel_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign bus.inst_o     = inst_o_q;
    assign bus.inst_ready = inst_ready_q;
    assign bus.data_o     = data_o_q;
    assign bus.data_ready = data_ready_q;

endmodule

// File: tb/tb_unified_mem_arb.sv
// Bench for unified_mem_arb: three instances (W=1/fair, W=0/data-priority, W=15/fair).
module tb_unified_mem_arb;

    function automatic int unsigned wc_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    endfunction

    function automatic int unsigned fair_of(input int g);
        return (g == 1) ? 0 : 1;
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        inst_ce   [3];
    logic [31:0] inst_addr [3];
    logic [31:0] inst_o    [3];
    logic        inst_ready[3];
    logic        data_ce   [3];
    logic        data_we   [3];
    logic [3:0]  data_sel  [3];
    logic [31:0] data_addr [3];
    logic [31:0] data_i    [3];
    logic [31:0] data_o    [3];
    logic        data_ready[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        unified_mem_arb_if #(.DATA_W(32)) bus ();
        assign bus.inst_ce   = inst_ce[g];
        assign bus.inst_addr = inst_addr[g];
        assign bus.data_ce   = data_ce[g];
        assign bus.data_we   = data_we[g];
        assign bus.data_sel  = data_sel[g];
        assign bus.data_addr = data_addr[g];
        assign bus.data_i    = data_i[g];
        assign inst_o[g]     = bus.inst_o;
        assign inst_ready[g] = bus.inst_ready;
        assign data_o[g]     = bus.data_o;
        assign data_ready[g] = bus.data_ready;

        unified_mem_arb #(
            .DATA_W      (32),
            .DEPTH       (1024),
            .WAIT_CYCLES (wc_of(g)),
            .FAIR        (fair_of(g))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h required %08h", name, act, exp);
    endtask

    // Reference model: word array per instance, expected port outputs, last grant.
    logic [31:0] mem_m [3][1024];
    logic [31:0] exp_io [3];
    logic [31:0] exp_do [3];
    bit          last_data [3];

    task automatic model_data(input int k, input bit we, input logic [3:0] sel,
                              input logic [31:0] da, input logic [31:0] wd);
        int idx = int'((da >> 2) % 1024);
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) mem_m[k][idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
            exp_do[k] = mem_m[k][idx];
        end
    endtask

    task automatic model_inst(input int k, input logic [31:0] ia);
        exp_io[k] = mem_m[k][int'((ia >> 2) % 1024)];
    endtask

    // Latency in edges after the sampling edge; the loser of a contention
    // waits one full transfer (lat+1 cycles) more.
    task automatic model_xfer(input int k, input bit doi, input bit dod, input bit we,
                              input logic [3:0] sel, input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] wd, output int eic, output int edc);
        int  lat = int'(wc_of(k)) + 2;
        bit  data_first;
        eic = 0;
        edc = 0;
        data_first = dod && (!doi || fair_of(k) == 0 || !last_data[k]);
        if (data_first) begin
            model_data(k, we, sel, da, wd);
            edc = lat;
            if (doi) begin
                model_inst(k, ia);
                eic = 2 * lat + 1;
            end
            last_data[k] = !doi;
        end else begin
            model_inst(k, ia);
            eic = lat;
            if (dod) begin
                model_data(k, we, sel, da, wd);
                edc = 2 * lat + 1;
            end
            last_data[k] = dod;
        end
    endtask

    // Drive one request set, drop each ce when its ready is seen.
    task automatic xfer(input int k, input bit doi, input bit dod, input bit we,
                        input logic [3:0] sel, input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, output int ic, output int dc,
                        output logic [31:0] io, output logic [31:0] dout, output bit ovl);
        inst_ce[k]   = doi;
        inst_addr[k] = ia;
        data_ce[k]   = dod;
        data_we[k]   = we;
        data_sel[k]  = sel;
        data_addr[k] = da;
        data_i[k]    = wd;
        ic = 0;
        dc = 0;
        ovl = 0;
        for (int n = 1; n <= 60 && ((doi && ic == 0) || (dod && dc == 0)); n++) begin
            @(negedge clk);
            if (inst_ready[k] && data_ready[k]) ovl = 1;
            if (inst_ready[k]) begin
                if (ic == 0) ic = n - 1;
                inst_ce[k] = 1'b0;
            end
            if (data_ready[k]) begin
                if (dc == 0) dc = n - 1;
                data_ce[k] = 1'b0;
            end
        end
        inst_ce[k] = 1'b0;
        data_ce[k] = 1'b0;
        io   = inst_o[k];
        dout = data_o[k];
    endtask

    task automatic run_model_check(input int k, input bit doi, input bit dod, input bit we,
                                   input logic [3:0] sel, input logic [31:0] ia,
                                   input logic [31:0] da, input logic [31:0] wd, input string tag);
        int eic, edc, ic, dc;
        logic [31:0] io, dout;
        bit ovl;
        model_xfer(k, doi, dod, we, sel, ia, da, wd, eic, edc);
        xfer(k, doi, dod, we, sel, ia, da, wd, ic, dc, io, dout, ovl);
        check({tag, " inst_lat"}, ic, eic);
        check({tag, " data_lat"}, dc, edc);
        check({tag, " inst_o"}, io, exp_io[k]);
        check({tag, " data_o"}, dout, exp_do[k]);
        check({tag, " overlap"}, {31'd0, ovl}, 32'd0);
    endtask

    task automatic check_all_reset(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s k%0d inst_ready", tag, k), {31'd0, inst_ready[k]}, 32'd0);
            check($sformatf("%s k%0d data_ready", tag, k), {31'd0, data_ready[k]}, 32'd0);
            check($sformatf("%s k%0d inst_o", tag, k), inst_o[k], 32'd0);
            check($sformatf("%s k%0d data_o", tag, k), data_o[k], 32'd0);
        end
    endtask

    typedef struct {
        int          k;
        bit          doi;
        bit          dod;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        int          eic;
        int          edc;
        logic [31:0] eio;
        logic [31:0] edo;
    } vec_t;

    vec_t vt [16];

    initial begin
        int ic, dc, eic, edc;
        logic [31:0] io, dout, pre;
        bit ovl;
        int order [4];
        int tstamp [4];
        int seen, n_inst, n_data;
        bit ovl_seq;

        // {k, inst, data, we, sel, inst_addr, data_addr, wdata, inst_lat, data_lat, inst_o, data_o}
        vt[0]  = '{0, 0, 1, 1, 4'hF, 32'h0,    32'h10, 32'h11223344, 0, 3, 32'h0, 32'h0};
        vt[1]  = '{0, 0, 1, 1, 4'h1, 32'h0,    32'h10, 32'h000000AA, 0, 3, 32'h0, 32'h0};
        vt[2]  = '{0, 0, 1, 0, 4'hF, 32'h0,    32'h10, 32'h0, 0, 3, 32'h0, 32'h112233AA};
        vt[3]  = '{0, 0, 1, 1, 4'hF, 32'h0,    32'h4,  32'hCAFEF00D, 0, 3, 32'h0, 32'h112233AA};
        vt[4]  = '{0, 1, 0, 0, 4'h0, 32'h1004, 32'h0,  32'h0, 3, 0, 32'hCAFEF00D, 32'h112233AA};
        vt[5]  = '{0, 1, 1, 0, 4'hF, 32'h10,   32'h4,  32'h0, 7, 3, 32'h112233AA, 32'hCAFEF00D};
        vt[6]  = '{0, 1, 1, 1, 4'h2, 32'h10,   32'h10, 32'h00005500, 7, 3, 32'h112255AA, 32'hCAFEF00D};
        vt[7]  = '{1, 0, 1, 1, 4'hF, 32'h0,    32'h20, 32'h0BADF00D, 0, 2, 32'h0, 32'h0};
        vt[8]  = '{1, 0, 1, 1, 4'h0, 32'h0,    32'h20, 32'hFFFFFFFF, 0, 2, 32'h0, 32'h0};
        vt[9]  = '{1, 0, 1, 0, 4'hF, 32'h0,    32'h20, 32'h0, 0, 2, 32'h0, 32'h0BADF00D};
        vt[10] = '{1, 1, 1, 1, 4'hF, 32'h20,   32'h20, 32'h12345678, 5, 2, 32'h12345678, 32'h0BADF00D};
        vt[11] = '{1, 1, 1, 0, 4'hF, 32'h1020, 32'h20, 32'h0, 5, 2, 32'h12345678, 32'h12345678};
        vt[12] = '{2, 0, 1, 1, 4'hF, 32'h0,    32'h0,  32'hA5A5A5A5, 0, 17, 32'h0, 32'h0};
        vt[13] = '{2, 0, 1, 1, 4'h0, 32'h0,    32'h0,  32'h0, 0, 17, 32'h0, 32'h0};
        vt[14] = '{2, 1, 0, 0, 4'h0, 32'h0,    32'h0,  32'h0, 17, 0, 32'hA5A5A5A5, 32'h0};
        vt[15] = '{2, 1, 1, 0, 4'hF, 32'h0,    32'h3,  32'h0, 35, 17, 32'hA5A5A5A5, 32'hA5A5A5A5};

        for (int k = 0; k < 3; k++) begin
            inst_ce[k] = 0; inst_addr[k] = '0; data_ce[k] = 0; data_we[k] = 0;
            data_sel[k] = '0; data_addr[k] = '0; data_i[k] = '0;
            exp_io[k] = '0; exp_do[k] = '0; last_data[k] = 0;
            for (int w = 0; w < 1024; w++) mem_m[k][w] = '0;
        end

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            model_xfer(vt[i].k, vt[i].doi, vt[i].dod, vt[i].we, vt[i].sel, vt[i].ia, vt[i].da,
                       vt[i].wd, eic, edc);
            xfer(vt[i].k, vt[i].doi, vt[i].dod, vt[i].we, vt[i].sel, vt[i].ia, vt[i].da,
                 vt[i].wd, ic, dc, io, dout, ovl);
            check($sformatf("vec%0d inst_lat", i), ic, vt[i].eic);
            check($sformatf("vec%0d data_lat", i), dc, vt[i].edc);
            check($sformatf("vec%0d inst_o", i), io, vt[i].eio);
            check($sformatf("vec%0d data_o", i), dout, vt[i].edo);
            check($sformatf("vec%0d overlap", i), {31'd0, ovl}, 32'd0);
        end

        // Fair contention: both held high for four transfers on instance 0
        for (int j = 0; j < 4; j++) begin order[j] = 2; tstamp[j] = 0; end
        seen = 0;
        ovl_seq = 0;
        inst_addr[0] = 32'h10; data_addr[0] = 32'h4; data_we[0] = 0; data_sel[0] = 4'hF;
        inst_ce[0] = 1; data_ce[0] = 1;
        for (int n = 1; n <= 100 && seen < 4; n++) begin
            @(negedge clk);
            if (inst_ready[0] && data_ready[0]) ovl_seq = 1;
            if (data_ready[0]) begin order[seen] = 1; tstamp[seen] = n; seen++; end
            else if (inst_ready[0]) begin order[seen] = 0; tstamp[seen] = n; seen++; end
        end
        inst_ce[0] = 0; data_ce[0] = 0;
        for (int j = 0; j < 4; j++)
            check($sformatf("rr grant%0d", j), order[j], (j % 2 == 0) ? 1 : 0);
        for (int j = 1; j < 4; j++)
            check($sformatf("rr spacing%0d", j), tstamp[j] - tstamp[j-1], 4);
        check("rr overlap", {31'd0, ovl_seq}, 32'd0);
        model_inst(0, 32'h10);
        model_data(0, 0, 4'hF, 32'h4, 32'h0);
        last_data[0] = 0;
        check("rr inst_o", inst_o[0], exp_io[0]);
        check("rr data_o", data_o[0], exp_do[0]);

        // Data priority: data_ce continuously high starves fetch on instance 1
        n_inst = 0;
        n_data = 0;
        inst_addr[1] = 32'h20; data_addr[1] = 32'h20; data_we[1] = 0; data_sel[1] = 4'hF;
        inst_ce[1] = 1; data_ce[1] = 1;
        for (int n = 1; n <= 60 && n_data < 5; n++) begin
            @(negedge clk);
            if (inst_ready[1]) n_inst++;
            if (data_ready[1]) n_data++;
        end
        data_ce[1] = 0;
        check("prio data count", n_data, 5);
        check("prio inst starved", n_inst, 0);
        seen = 0;
        for (int n = 1; n <= 10 && seen == 0; n++) begin
            @(negedge clk);
            if (inst_ready[1]) seen = n;
        end
        inst_ce[1] = 0;
        check("prio fetch after drop", seen, 3);
        model_inst(1, 32'h20);
        model_data(1, 0, 4'hF, 32'h20, 32'h0);
        check("prio inst_o", inst_o[1], exp_io[1]);
        check("prio data_o", data_o[1], exp_do[1]);

        // Preload known words for the randomized phase
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 32; w++)
                run_model_check(k, 0, 1, 1, 4'hF, 32'h0, 32'(w) << 2, $urandom,
                                $sformatf("pre k%0d w%0d", k, w));

        // Reset in the middle of a write access on instance 0
        pre = mem_m[0][16];
        data_addr[0] = 32'h40; data_i[0] = 32'hDEADBEEF; data_we[0] = 1; data_sel[0] = 4'hF;
        data_ce[0] = 1;
        @(negedge clk);
        rst_n = 1'b0;
        data_ce[0] = 0;
        #1;
        check_all_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin exp_io[k] = '0; exp_do[k] = '0; last_data[k] = 0; end
        @(negedge clk);
        run_model_check(0, 0, 1, 0, 4'hF, 32'h0, 32'h40, 32'h0, "post-reset read");
        check("post-reset old word", exp_do[0], pre);

        // Randomized traffic against the model
        for (int k = 0; k < 3; k++) begin
            for (int it = 0; it < 60; it++) begin
                int mode = int'($urandom_range(0, 2));
                logic [31:0] ia = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
                logic [31:0] da = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
                run_model_check(k, mode != 0, mode != 1, 1'($urandom), 4'($urandom), ia, da,
                                $urandom, $sformatf("rnd k%0d it%0d", k, it));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unified_mem_arb.md
# unified_mem_arb

Single-port unified instruction/data memory with a two-master arbiter, parametrised width, depth, wait states and arbitration mode. It replaces the separate instruction ROM and data RAM beside the CPU core: the instruction-fetch port and the load/store port share one byte-writable array through a request/ready handshake. Both ports stall until their access completes.

## Interface
Parameters:
- `DATA_W`, 32, word width; a multiple of 8. `SEL_W = DATA_W/8`.
- `DEPTH`, 1024, words in the array; a power of 2.
- `WAIT_CYCLES`, 1, extra access cycles per transfer; range 0..15.
- `FAIR`, 1, arbitration mode.
  - 1: round-robin when both ports request.
  - 0: the data port always has priority.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst_ce` in 1: fetch request; held high until `inst_ready`.
- `inst_addr` in 32: fetch byte address.
- `inst_o` out DATA_W: fetched word.
- `inst_ready` out 1: one-cycle completion pulse for the fetch port.
- `data_ce` in 1: load/store request; held high until `data_ready`.
- `data_we` in 1: 1 = write, 0 = read.
- `data_sel` in SEL_W: byte enables; bit i covers bits 8i+7:8i.
- `data_addr` in 32: load/store byte address.
- `data_i` in DATA_W: write data.
- `data_o` out DATA_W: read data.
- `data_ready` out 1: one-cycle completion pulse for the data port.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** if any `ce` is high at an edge, grant one port and go to ACCESS.
  - The granted port's addr, we, sel and wdata are latched, and the wait counter is loaded with WAIT_CYCLES.
  - Which port wins when both request:
    - FAIR=0: the data port.
    - FAIR=1: the port not granted last. After reset, the data port wins.
- **ACCESS:** while the counter is non-zero, decrement it. At the edge where it is 0:
  - perform the array read or write;
  - register the read word into the granted port's output register;
  - go to RESP.
- **RESP:** assert the granted port's `ready` for exactly one cycle, then go to IDLE unconditionally.
- Addressing:
  - Word index is `addr[log2(DEPTH)+1:2]`.
  - `addr[1:0]` and the high bits above the index are ignored, so accesses alias modulo DEPTH.
- Writes:
  - Only bytes with `sel` high are modified.
  - `sel=0` writes nothing but still completes with `ready`.
  - A write leaves `data_o` unchanged.
- Reads return the full word regardless of `sel`.
- The fetch port is read-only.
- Each output register holds its last value until that port's next completed read.
- `ce` dropping before `ready` is a protocol violation. The latched transfer still completes.

## Timing
- Reset values:
  - state IDLE;
  - `inst_ready=0`, `data_ready=0`;
  - `inst_o=0`, `data_o=0`;
  - last-grant = inst, so data wins first under FAIR=1.
  - Array contents are not reset.
- Latency: `ce` sampled high at edge 0 gives `ready` high in the cycle after edge WAIT_CYCLES+2. With WAIT_CYCLES=0, `ready` rises after the second edge.
- One transfer every WAIT_CYCLES+3 cycles.
- Because RESP always returns to IDLE, a master's still-high `ce` during its `ready` cycle is never re-captured.
- Simultaneous requests: the loser keeps `ce` high and is granted at the next IDLE edge. Under FAIR=1 the wait is bounded to one transfer.
- Reset mid-operation:
  - Reset before the commit edge in ACCESS: the write is discarded.
  - No `ready` is issued for the aborted transfer.
- `inst_ready` and `data_ready` are never high in the same cycle.

## Structure
- Shared macro header (`macro.v`) gains:
  - the FSM state encodings;
  - the port-id encoding (`PORT_INST=0`, `PORT_DATA=1`);
  - the default DATA_W/DEPTH values.
- Sub-module `unified_ram`: a single-port synchronous array with per-byte write enables and a registered read. The arbiter and FSM instantiate it.

## Test plan
- **Reset:** `rst_n` low mid-ACCESS of a write of 0xDEADBEEF to 0x40 → all outputs 0; a later read of 0x40 returns the pre-write value.
- **Byte write, WAIT_CYCLES=1:**
  - stimulus: write 0x11223344 to 0x10 with sel=1111, then 0x000000AA with sel=0001, then read;
  - response: 0x112233AA;
  - `data_ready` 3 cycles after each `ce` sample.
- **Alias, DEPTH=1024:** write 0xCAFEF00D at 0x0000_0004 → fetch from 0x0000_1004 returns 0xCAFEF00D.
- **Contention, FAIR=1:**
  - stimulus: both `ce` held high for 4 transfers;
  - response: grants data, inst, data, inst; `ready` pulses never overlap.
- **Contention, FAIR=0:** `data_ce` held high continuously → `inst_ready` stays 0; fetch completes one transfer after `data_ce` drops.
- **WAIT_CYCLES=0 vs 15:**
  - `ready` after 2 / 17 edges respectively;
  - `sel=0` write completes and leaves memory unchanged.
